cnn_pixel_streamer: RTL and testbench

// Frame buffer and pixel sequencer directly upstream of cnn_top. Captures one IX x IY frame

---
 rtl/cnn_pixel_streamer_if.sv | 33 +++
 rtl/cnn_pixel_streamer.sv | 162 ++++++++++++++++
 tb/tb_cnn_pixel_streamer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pixel_streamer_if.sv
// Pixel streamer bus: serial frame write port and
// raster-order output stream toward cnn_top.
interface cnn_pixel_streamer_if #(
    parameter int I_F_BW = 8
);
    logic              i_wr_valid;
    logic [I_F_BW-1:0] i_wr_pixel;
    logic              o_valid;
    logic [I_F_BW-1:0] o_pixel;
    logic              o_sof;
    logic              o_eol;
    logic              o_eof;

    modport master (
        output i_wr_valid,
        output i_wr_pixel,
        input  o_valid,
        input  o_pixel,
        input  o_sof,
        input  o_eol,
        input  o_eof
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_pixel,
        output o_valid,
        output o_pixel,
        output o_sof,
        output o_eol,
        output o_eof
    );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// Frame buffer that captures one IX x IY frame serially and
// replays it raster-order as a valid-qualified pixel stream.
module cnn_pixel_streamer #(
    parameter int I_F_BW  = 8,
    parameter int IX      = 28,
    parameter int IY      = 28,
    parameter int ROW_GAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    cnn_pixel_streamer_if.slave  bus,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic                 i_hold,
    output logic                 o_loaded,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int NPIX = IX * IY;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(IX);
    localparam int RW   = $clog2(IY);
    localparam int GW   = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_STREAM,
        ST_GAP,
        ST_FLUSH
    } state_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [GW-1:0]     gap_cnt;
    logic [I_F_BW-1:0] mem [NPIX];
    logic [I_F_BW-1:0] rd_q;
    logic              vld;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              issue;
    logic              wr_en;
    logic              last_col;
    logic              last_row;

    assign last_col = (col == CW'(IX - 1));
    assign last_row = (row == RW'(IY - 1));
    assign issue    = (state == ST_STREAM) && !i_hold && !i_clear;
    assign wr_en    = (state == ST_IDLE) && bus.i_wr_valid
                      && !i_clear && !reset;

    // Frame storage: serial write, one-cycle synchronous read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.i_wr_pixel;
        end
        if (issue) begin
            rd_q <= mem[rd_ptr];
        end
    end

    // Sequencer: load, replay, row gaps and registered stream markers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            col      <= '0;
            row      <= '0;
            gap_cnt  <= '0;
            vld      <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            eof      <= 1'b0;
            o_done   <= 1'b0;
            o_loaded <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            vld    <= issue;
            sof    <= issue && (rd_ptr == '0);
            eol    <= issue && last_col;
            eof    <= issue && last_col && last_row;
            o_done <= issue && last_col && last_row;
            if (i_clear) begin
                state    <= ST_IDLE;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                col      <= '0;
                row      <= '0;
                gap_cnt  <= '0;
                o_loaded <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.i_wr_valid) begin
                            if (wr_ptr == AW'(NPIX - 1)) begin
                                wr_ptr   <= '0;
                                state    <= ST_READY;
                                o_loaded <= 1'b1;
                            end else begin
                                wr_ptr <= wr_ptr + AW'(1);
                            end
                        end
                    end
                    ST_READY: begin
                        if (i_start) begin
                            state  <= ST_STREAM;
                            o_busy <= 1'b1;
                            rd_ptr <= '0;
                            col    <= '0;
                            row    <= '0;
                        end
                    end
                    ST_STREAM: begin
                        if (!i_hold) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            if (last_col) begin
                                col <= '0;
                                if (last_row) begin
                                    state <= ST_FLUSH;
                                end else begin
                                    row <= row + RW'(1);
                                    if (ROW_GAP > 0) begin
                                        state   <= ST_GAP;
                                        gap_cnt <= '0;
                                    end
                                end
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (!i_hold) begin
                            if (gap_cnt == GW'(ROW_GAP - 1)) begin
                                state <= ST_STREAM;
                            end else begin
                                gap_cnt <= gap_cnt + GW'(1);
                            end
                        end
                    end
                    ST_FLUSH: begin
                        state  <= ST_READY;
                        o_busy <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_valid = vld;
    assign bus.o_pixel = vld ? rd_q : '0;
    assign bus.o_sof   = sof;
    assign bus.o_eol   = eol;
    assign bus.o_eof   = eof;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Directed bench for cnn_pixel_streamer: two instances,
// ROW_GAP=0 and ROW_GAP=3, sharing load/start/clear/reset.
module tb_cnn_pixel_streamer;
    localparam int BW   = 8;
    localparam int IX   = 28;
    localparam int IY   = 28;
    localparam int NPIX = IX * IY;
    localparam int GAP  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic clr   = 1'b0;
    logic start = 1'b0;
    logic hold0 = 1'b0;
    logic hold1 = 1'b0;
    logic ld0, bsy0, dn0;
    logic ld1, bsy1, dn1;

    cnn_pixel_streamer_if #(.I_F_BW(BW)) bus0 ();
    cnn_pixel_streamer_if #(.I_F_BW(BW)) bus1 ();

    cnn_pixel_streamer #(
        .I_F_BW(BW), .IX(IX), .IY(IY), .ROW_GAP(0)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0),
        .i_clear  (clr),
        .i_start  (start),
        .i_hold   (hold0),
        .o_loaded (ld0),
        .o_busy   (bsy0),
        .o_done   (dn0)
    );

    cnn_pixel_streamer #(
        .I_F_BW(BW), .IX(IX), .IY(IY), .ROW_GAP(GAP)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus1),
        .i_clear  (clr),
        .i_start  (start),
        .i_hold   (hold1),
        .o_loaded (ld1),
        .o_busy   (bsy1),
        .o_done   (dn1)
    );

    typedef struct {
        int px;
        bit sof;
        bit eol;
        bit eof;
        bit done;
        int cyc;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   cyc   = 0;
    int   done0 = 0;
    int   done1 = 0;
    int   zbad  = 0;
    int   nchk  = 0;
    int   nerr  = 0;
    int   n;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat; count idle cycles with non-zero data/markers
    always @(negedge clk) begin
        if (bus0.o_valid === 1'b1)
            q0.push_back('{px: int'(bus0.o_pixel), sof: bus0.o_sof,
                           eol: bus0.o_eol, eof: bus0.o_eof,
                           done: dn0, cyc: cyc});
        else if (bus0.o_pixel != 0 || bus0.o_sof || bus0.o_eol
                 || bus0.o_eof || dn0)
            zbad++;
        if (bus1.o_valid === 1'b1)
            q1.push_back('{px: int'(bus1.o_pixel), sof: bus1.o_sof,
                           eol: bus1.o_eol, eof: bus1.o_eof,
                           done: dn1, cyc: cyc});
        else if (bus1.o_pixel != 0 || bus1.o_sof || bus1.o_eol
                 || bus1.o_eof || dn1)
            zbad++;
        if (dn0 === 1'b1) done0++;
        if (dn1 === 1'b1) done1++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int from, input int to, input int fill);
        for (int i = from; i < to; i++) begin
            bus0.i_wr_valid = 1'b1;
            bus1.i_wr_valid = 1'b1;
            bus0.i_wr_pixel = (fill < 0) ? 8'(i) : 8'(fill);
            bus1.i_wr_pixel = (fill < 0) ? 8'(i) : 8'(fill);
            tick();
        end
        bus0.i_wr_valid = 1'b0;
        bus1.i_wr_valid = 1'b0;
    endtask

    task automatic go(output int s);
        q0.delete();
        q1.delete();
        done0 = 0;
        done1 = 0;
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while ((done0 < 1 || done1 < 1) && k < 5000) begin
            tick();
            k++;
        end
        chk(tag, int'(done0 >= 1 && done1 >= 1), 1);
        tick(3);
    endtask

    task automatic vframe(input string tag, input rec_t q[$],
                          input int fill, input int s, input int span);
        int bad = 0;
        int ex;
        chk({tag, "_beats"}, q.size(), NPIX);
        chk({tag, "_first"}, (q.size() > 0) ? q[0].cyc : -1, s + 2);
        for (int i = 0; i < q.size(); i++) begin
            ex = (fill < 0) ? (i % 256) : fill;
            if (q[i].px != ex || q[i].sof != (i == 0)
                || q[i].eol != ((i % IX) == IX - 1)
                || q[i].eof != (i == NPIX - 1)
                || q[i].done != (i == NPIX - 1))
                bad++;
        end
        chk({tag, "_content"}, bad, 0);
        chk({tag, "_span"},
            (q.size() > 0) ? q[q.size()-1].cyc - q[0].cyc + 1 : -1, span);
    endtask

    initial begin
        bus0.i_wr_valid = 1'b0;
        bus1.i_wr_valid = 1'b0;
        bus0.i_wr_pixel = '0;
        bus1.i_wr_pixel = '0;
        tick(3);
        chk("rst_valid", int'(bus0.o_valid), 0);
        chk("rst_loaded", int'(ld0), 0);
        chk("rst_busy", int'(bsy0), 0);
        chk("rst_done", int'(dn0), 0);
        reset = 1'b0;
        tick();

        load(0, 100, -1);
        go(n);
        tick(4);
        chk("early_start_busy", int'(bsy0), 0);
        chk("early_start_beats", q0.size() + q1.size(), 0);

        load(100, NPIX - 1, -1);
        chk("loaded_before_last", int'(ld0), 0);
        load(NPIX - 1, NPIX, -1);
        chk("loaded_after_last0", int'(ld0), 1);
        chk("loaded_after_last1", int'(ld1), 1);
        load(NPIX, NPIX + 16, 255);

        go(n);
        chk("busy_after_start", int'(bsy0), 1);
        wait_done("f1_timeout");
        vframe("f1_g0", q0, -1, n, NPIX);
        vframe("f1_g3", q1, -1, n, NPIX + (IY - 1) * GAP);
        chk("f1_busy_after0", int'(bsy0), 0);
        chk("f1_busy_after1", int'(bsy1), 0);
        chk("f1_done_count", done0 + done1, 2);

        go(n);
        while (cyc < n + 60) begin
            hold0 = (cyc >= n + 41 && cyc <= n + 45);
            hold1 = (cyc >= n + 30 && cyc <= n + 34);
            tick();
        end
        hold0 = 1'b0;
        hold1 = 1'b0;
        wait_done("hold_timeout");
        vframe("hold_g0", q0, -1, n, NPIX + 5);
        vframe("hold_g3", q1, -1, n, NPIX + (IY - 1) * GAP + 5);
        chk("hold_stream_gap",
            (q0.size() > 40) ? q0[40].cyc - q0[39].cyc : -1, 6);
        chk("hold_row_gap",
            (q1.size() > 28) ? q1[28].cyc - q1[27].cyc : -1, 9);

        go(n);
        while (cyc < n + 302) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_valid", int'(bus0.o_valid), 0);
        chk("clear_loaded", int'(ld0), 0);
        tick(20);
        chk("clear_beats", q0.size(), 301);
        chk("clear_last_px",
            (q0.size() > 0) ? q0[q0.size()-1].px : -1, 300 % 256);
        chk("clear_no_done", done0, 0);
        chk("clear_busy", int'(bsy0), 0);

        load(0, NPIX, 'hA5);
        chk("reload_loaded", int'(ld0), 1);
        go(n);
        wait_done("a5_timeout");
        vframe("a5_g0", q0, 'hA5, n, NPIX);
        vframe("a5_g3", q1, 'hA5, n, NPIX + (IY - 1) * GAP);

        go(n);
        while (cyc < n + 502) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", int'(bus0.o_valid), 0);
        chk("mid_rst_loaded", int'(ld0), 0);
        chk("mid_rst_busy", int'(bsy0), 0);
        chk("mid_rst_done", int'(dn0), 0);
        chk("mid_rst_beats", q0.size(), 501);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(10);
        chk("post_rst_start_busy", int'(bsy0), 0);
        chk("post_rst_start_beats", q0.size(), 501);
        chk("idle_zero_outputs", zbad, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
